vga_scan_engine: RTL and testbench
==================================

// Module: vga_scan_engine
// PURPOSE
//   Parametrised VGA scan-out engine: generates sync timing, framebuffer read addresses and RGB pins.
//   Successor to the fixed 640x480 VGA block, with generic timing and polarity, selectable channel depth,
//   integer pixel scaling (1x/2x/4x), read-latency compensation and a built-in colour-bar pattern.
//   Sits between the framebuffer BRAM read port and the board VGA connector.
// PARAMETERS
//   CLK_DIV   4    CLK100MHZ cycles per pixel tick (4 -> 25 MHz)
//   H_ACTIVE  640  visible pixels/line; H_FP 16, H_SYNC 96, H_BP 48 (pixel ticks)
//   V_ACTIVE  480  visible lines/frame; V_FP 10, V_SYNC 2, V_BP 33 (lines)
//   HS_POL    0    asserted level of VGA_HS; VS_POL 0, asserted level of VGA_VS
//   CW        4    bits per colour channel
//   RD_LAT    1    framebuffer read latency in pixel ticks (>=1)
//   ADDR_W    19   framebuffer address width (>= clog2(H_ACTIVE*V_ACTIVE))
// PORTS
//   CLK100MHZ    in   1       system clock, sole clock
//   rst          in   1       asynchronous, active-high reset
//   scale_sel    in   2       0:1x 1:2x 2:4x 3:treated as 4x; sampled only at frame start
//   pattern_en   in   1       1: drive colour bars instead of rdata_vga; sampled at frame start
//   rdata_vga    in   3*CW    framebuffer pixel {R,G,B}, RD_LAT ticks after raddr_vga
//   raddr_vga    out  ADDR_W  framebuffer read address
//   VGA_R/G/B    out  CW      colour pins, each CW bits
//   VGA_HS       out  1       horizontal sync
//   VGA_VS       out  1       vertical sync
//   pix_ce       out  1       one-CLK100MHZ-cycle pixel-tick strobe
//   frame_start  out  1       one-cycle pulse, coincident with pix_ce at counters (0,0)
// BEHAVIOUR
//   - Reset: div/h/v counters, row base, scale_q, pattern_q, raddr_vga, VGA_R/G/B, pix_ce, frame_start
//     all 0; VGA_HS = ~HS_POL, VGA_VS = ~VS_POL. Reset mid-frame aborts the frame; restarts at (0,0).
//   - Divider counts 0..CLK_DIV-1 and wraps; pix_ce=1 in the cycle it equals CLK_DIV-1.
//   - All pixel-domain state advances only on pix_ce (clock enable, no derived clocks).
//   - hcnt 0..H_TOTAL-1 (H_TOTAL = sum of H_*), wraps to 0. vcnt increments on hcnt wrap and wraps
//     at V_TOTAL-1. First pix_ce after reset is at (0,0), so it raises frame_start.
//   - On frame_start: scale_q<=scale_sel (3->2), pattern_q<=pattern_en. Changes mid-frame are ignored.
//   - active = hcnt<H_ACTIVE && vcnt<V_ACTIVE. hs = hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
//     vs = vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC). Pins drive POL when asserted.
//   - Address, no multiplier: row_base register is reset to 0 at frame start. On line wrap, when
//     (vcnt+1) mod 2^scale_q == 0, row_base += H_ACTIVE>>scale_q.
//     Address = row_base + (hcnt>>scale_q), registered on pix_ce; 0 when not active. Arithmetic mod 2^ADDR_W.
//   - Alignment: active/hs/vs/bar index pass through an (RD_LAT+1)-stage pix_ce-enabled delay line,
//     so pins for pixel (h,v) appear exactly RD_LAT+1 ticks after raddr_vga carries its address.
//     HS/VS/RGB stay mutually aligned; sync widths and periods are unchanged.
//   - RGB (registered): delayed active=0 -> all zero. pattern_q=1 -> bar i = (h*8)/H_ACTIVE;
//     R=all ones if i[2], G if i[1], B if i[0]. Otherwise the rdata_vga fields.
//   - With default timing, frame period = 800*525*4 = 1,680,000 CLK100MHZ cycles.
// TESTING
//   1 Defaults, 2 frames: HS period 3200 clk, asserted 384 clk; VS period 525 lines, asserted 2 lines;
//     frame_start every 1,680,000 clk.
//   2 scale_sel=0: address at (h=5,v=2) is 1285; last visible pixel is 307199; raddr 0 in blanking.
//   3 scale_sel=1: (h=5,v=3) -> 322; lines 2 and 3 issue identical addresses.
//     scale_sel changed at v=100 takes effect only after the next frame_start.
//   4 RD_LAT=2, BRAM model returns addr[11:0]: pins equal the model data, in step with HS/VS;
//     zero throughout blanking.
//   5 pattern_en=1: pixels h=240..319 -> R=0, G=F, B=F; h=560..639 -> R=F, G=F, B=F.
//   6 rst pulsed mid-line (async, between clock edges): outputs clear immediately, HS/VS go to the
//     inactive level (1); after release, frame_start fires on the first pix_ce.

Source files
------------

// File: rtl/vga_scan_engine_if.sv
// Framebuffer read port and VGA pin bundle for vga_scan_engine.
// The engine takes the master side; the BRAM wrapper and board pins take the slave side.
interface vga_scan_engine_if #(
    parameter int CW     = 4,
    parameter int ADDR_W = 19
);
    logic [ADDR_W-1:0] raddr_vga;
    logic [3*CW-1:0]   rdata_vga;
    logic [CW-1:0]     VGA_R;
    logic [CW-1:0]     VGA_G;
    logic [CW-1:0]     VGA_B;
    logic              VGA_HS;
    logic              VGA_VS;
    logic              pix_ce;
    logic              frame_start;

    modport master (
        output raddr_vga, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, pix_ce, frame_start,
        input  rdata_vga
    );

    modport slave (
        input  raddr_vga, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, pix_ce, frame_start,
        output rdata_vga
    );
endinterface

// File: rtl/vga_scan_engine.sv
// VGA scan-out engine: pixel-tick divider, h/v timing, multiplier-free scaled framebuffer
// addressing, read-latency-aligned sync/colour pipeline and built-in colour bars.
module vga_scan_engine #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 4,
    parameter int RD_LAT   = 1,
    parameter int ADDR_W   = 19
) (
    input  logic                 CLK100MHZ,
    input  logic                 rst,
    input  logic [1:0]           scale_sel,
    input  logic                 pattern_en,
    vga_scan_engine_if.master    vif
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int DL       = RD_LAT + 1;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [DW-1:0]     div_q, div_d;
    logic [HW-1:0]     hcnt_q, hcnt_d;
    logic [VW-1:0]     vcnt_q, vcnt_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [1:0]        scale_q, scale_d;
    logic              pattern_q, pattern_d;
    logic [DL-1:0]     act_dly_q, act_dly_d;
    logic [DL-1:0]     hs_dly_q, hs_dly_d;
    logic [DL-1:0]     vs_dly_q, vs_dly_d;
    logic [3*DL-1:0]   bar_dly_q, bar_dly_d;
    logic [CW-1:0]     r_q, r_d, g_q, g_d, b_q, b_d;
    logic              hs_pin_q, hs_pin_d;
    logic              vs_pin_q, vs_pin_d;

    logic              pix_ce;
    logic              at_origin;
    logic              line_end;
    logic              last_line;
    logic              active;
    logic              hs_raw;
    logic              vs_raw;
    logic [31:0]       h32;
    logic [31:0]       v32;
    logic [VW-1:0]     v_inc;
    logic [VW-1:0]     v_mask;
    logic [ADDR_W-1:0] h_scaled;
    logic [6:0]        bar_ge;
    logic [2:0]        bar_idx;
    logic              act_last;
    logic [2:0]        bar_last;

    assign pix_ce    = (div_q == DW'(CLK_DIV - 1));
    assign at_origin = (hcnt_q == '0) && (vcnt_q == '0);
    assign line_end  = (hcnt_q == HW'(H_TOTAL - 1));
    assign last_line = (vcnt_q == VW'(V_TOTAL - 1));
    assign h32       = 32'(hcnt_q);
    assign v32       = 32'(vcnt_q);
    assign active    = (h32 < 32'(H_ACTIVE)) && (v32 < 32'(V_ACTIVE));
    assign hs_raw    = (h32 >= 32'(HS_START)) && (h32 < 32'(HS_END));
    assign vs_raw    = (v32 >= 32'(VS_START)) && (v32 < 32'(VS_END));
    assign v_inc     = vcnt_q + 1'b1;
    assign v_mask    = (VW'(1) << scale_q) - VW'(1);
    assign h_scaled  = ADDR_W'(hcnt_q >> scale_q);

    // Bar index (h*8)/H_ACTIVE as a thermometer count of constant thresholds, no divider.
    for (genvar gi = 1; gi < 8; gi++) begin : g_bar
        assign bar_ge[gi-1] = ((h32 << 3) >= 32'(gi * H_ACTIVE));
    end
    assign bar_idx  = 3'($countones(bar_ge));

    assign act_last = act_dly_q[DL-1];
    assign bar_last = bar_dly_q[3*DL-1 -: 3];

    always_comb begin
        div_d      = pix_ce ? '0 : div_q + 1'b1;
        hcnt_d     = hcnt_q;
        vcnt_d     = vcnt_q;
        row_base_d = row_base_q;
        raddr_d    = raddr_q;
        scale_d    = scale_q;
        pattern_d  = pattern_q;
        act_dly_d  = act_dly_q;
        hs_dly_d   = hs_dly_q;
        vs_dly_d   = vs_dly_q;
        bar_dly_d  = bar_dly_q;
        r_d        = r_q;
        g_d        = g_q;
        b_d        = b_q;
        hs_pin_d   = hs_pin_q;
        vs_pin_d   = vs_pin_q;

        if (pix_ce) begin
            hcnt_d = line_end ? '0 : hcnt_q + 1'b1;
            if (line_end) begin
                vcnt_d = last_line ? '0 : vcnt_q + 1'b1;
                // Advance one scaled row each time 2^scale source lines have been shown.
                if (last_line) begin
                    row_base_d = '0;
                end else if ((v_inc & v_mask) == '0) begin
                    row_base_d = row_base_q + (ADDR_W'(H_ACTIVE) >> scale_q);
                end
            end
            if (at_origin) begin
                scale_d    = (scale_sel == 2'd3) ? 2'd2 : scale_sel;
                pattern_d  = pattern_en;
                row_base_d = '0;
            end

            raddr_d   = active ? (row_base_q + h_scaled) : '0;

            act_dly_d = {act_dly_q[DL-2:0], active};
            hs_dly_d  = {hs_dly_q[DL-2:0], hs_raw};
            vs_dly_d  = {vs_dly_q[DL-2:0], vs_raw};
            bar_dly_d = {bar_dly_q[3*DL-4:0], bar_idx};

            hs_pin_d  = hs_dly_q[DL-1] ? HS_POL : ~HS_POL;
            vs_pin_d  = vs_dly_q[DL-1] ? VS_POL : ~VS_POL;

            if (!act_last) begin
                r_d = '0;
                g_d = '0;
                b_d = '0;
            end else if (pattern_q) begin
                r_d = {CW{bar_last[2]}};
                g_d = {CW{bar_last[1]}};
                b_d = {CW{bar_last[0]}};
            end else begin
                r_d = vif.rdata_vga[3*CW-1 -: CW];
                g_d = vif.rdata_vga[2*CW-1 -: CW];
                b_d = vif.rdata_vga[CW-1:0];
            end
        end
    end

    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            div_q      <= '0;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            row_base_q <= '0;
            raddr_q    <= '0;
            scale_q    <= '0;
            pattern_q  <= 1'b0;
            act_dly_q  <= '0;
            hs_dly_q   <= '0;
            vs_dly_q   <= '0;
            bar_dly_q  <= '0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
            hs_pin_q   <= ~HS_POL;
            vs_pin_q   <= ~VS_POL;
        end else begin
            div_q      <= div_d;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            row_base_q <= row_base_d;
            raddr_q    <= raddr_d;
            scale_q    <= scale_d;
            pattern_q  <= pattern_d;
            act_dly_q  <= act_dly_d;
            hs_dly_q   <= hs_dly_d;
            vs_dly_q   <= vs_dly_d;
            bar_dly_q  <= bar_dly_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
            hs_pin_q   <= hs_pin_d;
            vs_pin_q   <= vs_pin_d;
        end
    end

    assign vif.raddr_vga   = raddr_q;
    assign vif.VGA_R       = r_q;
    assign vif.VGA_G       = g_q;
    assign vif.VGA_B       = b_q;
    assign vif.VGA_HS      = hs_pin_q;
    assign vif.VGA_VS      = vs_pin_q;
    assign vif.pix_ce      = pix_ce;
    assign vif.frame_start = pix_ce && at_origin;

endmodule

// File: tb/tb_vga_scan_engine.sv
// Bench for vga_scan_engine on a shrunken 16x8 raster (24x13 total) with RD_LAT=2, checked
// every clock against an arithmetic model of position, address and pin timing.
module tb_vga_scan_engine;

    localparam int D   = 4;
    localparam int HA  = 16;
    localparam int HFP = 2;
    localparam int HSY = 3;
    localparam int HBP = 3;
    localparam int HT  = HA + HFP + HSY + HBP;
    localparam int VA  = 8;
    localparam int VFP = 1;
    localparam int VSY = 2;
    localparam int VBP = 2;
    localparam int VT  = VA + VFP + VSY + VBP;
    localparam int FT  = HT * VT;
    localparam int CW  = 4;
    localparam int AW  = 12;
    localparam int LAT = 2;
    localparam int PL  = LAT + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] scale_sel = 2'd0;
    logic       pattern_en = 1'b0;

    int total = 0;
    int bad   = 0;

    vga_scan_engine_if #(.CW(CW), .ADDR_W(AW)) vif ();

    vga_scan_engine #(
        .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW), .RD_LAT(LAT), .ADDR_W(AW)
    ) dut (
        .CLK100MHZ (clk),
        .rst       (rst),
        .scale_sel (scale_sel),
        .pattern_en(pattern_en),
        .vif       (vif.master)
    );

    always #5 clk = ~clk;

    // Bench-side time base: cycles since reset release, plus per-frame captured settings.
    int         cyc;
    int         fr_scale [0:63];
    bit         fr_pat   [0:63];
    logic [11:0] key;
    logic [11:0] rd_pipe [LAT];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc <= 0;
        end else begin
            if ((cyc % D == D - 1) && ((cyc / D) % FT == 0)) begin
                fr_scale[((cyc / D) / FT) % 64] <= (scale_sel == 2'd3) ? 2 : int'(scale_sel);
                fr_pat[((cyc / D) / FT) % 64]   <= pattern_en;
            end
            cyc <= cyc + 1;
        end
    end

    // Framebuffer model: data = address XOR key, LAT pixel ticks after the address.
    always @(posedge clk) begin
        if (vif.pix_ce) begin
            rd_pipe[0] <= vif.raddr_vga ^ key;
            for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign vif.rdata_vga = rd_pipe[LAT-1];

    function automatic int exp_addr(int p);
        int h, v, s;
        if (p < 0) return 0;
        h = p % HT;
        v = (p / HT) % VT;
        s = fr_scale[(p / FT) % 64];
        if (h >= HA || v >= VA) return 0;
        return ((v >> s) * (HA >> s) + (h >> s)) % (1 << AW);
    endfunction

    function automatic logic [11:0] exp_rgb(int p);
        int h, v, i;
        logic [3:0] r, g, b;
        if (p < 0) return 12'h000;
        h = p % HT;
        v = (p / HT) % VT;
        if (h >= HA || v >= VA) return 12'h000;
        if (fr_pat[(p / FT) % 64]) begin
            i = (h * 8) / HA;
            r = ((i & 4) != 0) ? 4'hF : 4'h0;
            g = ((i & 2) != 0) ? 4'hF : 4'h0;
            b = ((i & 1) != 0) ? 4'hF : 4'h0;
            return {r, g, b};
        end
        return 12'(exp_addr(p)) ^ key;
    endfunction

    function automatic logic exp_hs(int p);
        int h;
        if (p < 0) return 1'b1;
        h = p % HT;
        return (h >= HA + HFP && h < HA + HFP + HSY) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic exp_vs(int p);
        int v;
        if (p < 0) return 1'b1;
        v = (p / HT) % VT;
        return (v >= VA + VFP && v < VA + VFP + VSY) ? 1'b0 : 1'b1;
    endfunction

    // Park on the first cycle of a frame so settings driven now are captured by its frame_start.
    task automatic align_frame;
        @(negedge clk);
        while (!((cyc % D == 0) && ((cyc / D) % FT == 0))) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (vif.raddr_vga !== 12'h000) begin bad++; $display("FAIL reset_raddr got=%0h want=0", vif.raddr_vga); end
        total++; if ({vif.VGA_R, vif.VGA_G, vif.VGA_B} !== 12'h000) begin bad++; $display("FAIL reset_rgb got=%0h want=0", {vif.VGA_R, vif.VGA_G, vif.VGA_B}); end
        total++; if (vif.VGA_HS !== 1'b1) begin bad++; $display("FAIL reset_hs got=%0b want=1", vif.VGA_HS); end
        total++; if (vif.VGA_VS !== 1'b1) begin bad++; $display("FAIL reset_vs got=%0b want=1", vif.VGA_VS); end
        total++; if (vif.pix_ce !== 1'b0) begin bad++; $display("FAIL reset_pix_ce got=%0b want=0", vif.pix_ce); end
        total++; if (vif.frame_start !== 1'b0) begin bad++; $display("FAIL reset_frame_start got=%0b want=0", vif.frame_start); end
        rst = 1'b0;
        $display("reset: released");
    endtask

    task automatic test_timing;
        int c, n, fs_cnt, last_fs;
        logic pce, fs;
        fs_cnt  = 0;
        last_fs = -1;
        repeat (2 * FT * D) begin
            @(negedge clk);
            c   = cyc;
            n   = c / D;
            pce = (c % D == D - 1);
            fs  = pce && (n % FT == 0);
            total++; if (vif.pix_ce !== pce) begin bad++; $display("FAIL timing_pix_ce cyc=%0d got=%0b want=%0b", c, vif.pix_ce, pce); end
            total++; if (vif.frame_start !== fs) begin bad++; $display("FAIL timing_frame_start cyc=%0d got=%0b want=%0b", c, vif.frame_start, fs); end
            total++; if (vif.VGA_HS !== exp_hs(n - PL)) begin bad++; $display("FAIL timing_hs cyc=%0d got=%0b want=%0b", c, vif.VGA_HS, exp_hs(n - PL)); end
            total++; if (vif.VGA_VS !== exp_vs(n - PL)) begin bad++; $display("FAIL timing_vs cyc=%0d got=%0b want=%0b", c, vif.VGA_VS, exp_vs(n - PL)); end
            if (vif.frame_start === 1'b1) begin
                if (last_fs >= 0) begin
                    total++; if (c - last_fs != FT * D) begin bad++; $display("FAIL timing_frame_period got=%0d want=%0d", c - last_fs, FT * D); end
                end
                last_fs = c;
                fs_cnt++;
            end
        end
        total++; if (fs_cnt != 2) begin bad++; $display("FAIL timing_frame_count got=%0d want=2", fs_cnt); end
        $display("timing: 2 frames checked, frame_starts=%0d", fs_cnt);
    endtask

    task automatic test_addr(input logic [1:0] sel, input int frames, input bit mid_change, input logic [1:0] new_sel);
        int c, n, p, ea;
        bit changed;
        changed = 1'b0;
        align_frame();
        scale_sel = sel;
        repeat (frames * FT * D) begin
            @(negedge clk);
            c = cyc;
            n = c / D;
            p = n - 1;
            if (mid_change && !changed && ((n % FT) / HT == 4)) begin
                scale_sel = new_sel;
                changed   = 1'b1;
            end
            ea = exp_addr(p);
            total++; if (vif.raddr_vga !== 12'(ea)) begin bad++; $display("FAIL addr cyc=%0d pos=%0d got=%0d want=%0d", c, p, vif.raddr_vga, ea); end
            if (p >= 0 && (p % FT) == 2 * HT + 5 && fr_scale[(p / FT) % 64] == 0) begin
                total++; if (vif.raddr_vga !== 12'd37) begin bad++; $display("FAIL addr_1x_h5v2 got=%0d want=37", vif.raddr_vga); end
            end
            if (p >= 0 && (p % FT) == 3 * HT + 5 && fr_scale[(p / FT) % 64] == 1) begin
                total++; if (vif.raddr_vga !== 12'd10) begin bad++; $display("FAIL addr_2x_h5v3 got=%0d want=10", vif.raddr_vga); end
            end
        end
        $display("addr: scale_sel=%0d frames=%0d mid_change=%0b", sel, frames, mid_change);
    endtask

    task automatic test_pixels(input logic [1:0] sel, input bit pat, input int frames);
        int c, n, p;
        logic [11:0] er;
        logic [11:0] got;
        align_frame();
        scale_sel  = sel;
        pattern_en = pat;
        repeat (frames * FT * D) begin
            @(negedge clk);
            c   = cyc;
            n   = c / D;
            p   = n - PL;
            er  = exp_rgb(p);
            got = {vif.VGA_R, vif.VGA_G, vif.VGA_B};
            total++; if (got !== er) begin bad++; $display("FAIL rgb cyc=%0d pos=%0d got=%03h want=%03h", c, p, got, er); end
            total++; if (vif.VGA_HS !== exp_hs(p)) begin bad++; $display("FAIL rgb_hs cyc=%0d got=%0b want=%0b", c, vif.VGA_HS, exp_hs(p)); end
            total++; if (vif.VGA_VS !== exp_vs(p)) begin bad++; $display("FAIL rgb_vs cyc=%0d got=%0b want=%0b", c, vif.VGA_VS, exp_vs(p)); end
            if (p >= 0 && fr_pat[(p / FT) % 64] && (p % HT) == 6 && ((p / HT) % VT) < VA) begin
                total++; if (got !== 12'h0FF) begin bad++; $display("FAIL bar_cyan got=%03h want=0ff", got); end
            end
            if (p >= 0 && fr_pat[(p / FT) % 64] && (p % HT) == 15 && ((p / HT) % VT) < VA) begin
                total++; if (got !== 12'hFFF) begin bad++; $display("FAIL bar_white got=%03h want=fff", got); end
            end
        end
        pattern_en = 1'b0;
        $display("pixels: scale_sel=%0d pattern=%0b frames=%0d", sel, pat, frames);
    endtask

    task automatic test_async_reset;
        int wait_cyc;
        bit seen;
        align_frame();
        wait_cyc = (3 * HT + int'($urandom_range(2, 10))) * D + int'($urandom_range(0, 3));
        repeat (wait_cyc) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (vif.raddr_vga !== 12'h000) begin bad++; $display("FAIL arst_raddr got=%0h want=0", vif.raddr_vga); end
        total++; if ({vif.VGA_R, vif.VGA_G, vif.VGA_B} !== 12'h000) begin bad++; $display("FAIL arst_rgb got=%03h want=000", {vif.VGA_R, vif.VGA_G, vif.VGA_B}); end
        total++; if (vif.VGA_HS !== 1'b1) begin bad++; $display("FAIL arst_hs got=%0b want=1", vif.VGA_HS); end
        total++; if (vif.VGA_VS !== 1'b1) begin bad++; $display("FAIL arst_vs got=%0b want=1", vif.VGA_VS); end
        total++; if (vif.pix_ce !== 1'b0) begin bad++; $display("FAIL arst_pix_ce got=%0b want=0", vif.pix_ce); end
        scale_sel = 2'($urandom_range(0, 3));
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2 * D; i++) begin
            @(negedge clk);
            if (vif.pix_ce === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL arst_first_pix_ce got=none want=pix_ce within %0d cycles", 2 * D);
        end else begin
            total++; if (vif.frame_start !== 1'b1) begin bad++; $display("FAIL arst_frame_start got=%0b want=1", vif.frame_start); end
            total++; if (cyc != D - 1) begin bad++; $display("FAIL arst_first_tick_cycle got=%0d want=%0d", cyc, D - 1); end
        end
        $display("async_reset: pulsed after %0d cycles into frame", wait_cyc);
    endtask

    task automatic test_random(input int frames);
        int c, n, pa, pp, chg_at;
        logic [11:0] er;
        logic [11:0] got;
        for (int f = 0; f < frames; f++) begin
            align_frame();
            scale_sel  = 2'($urandom_range(0, 3));
            pattern_en = 1'($urandom_range(0, 1));
            chg_at     = int'($urandom_range(D * HT, D * HT * VA));
            $display("random: frame %0d scale_sel=%0d pattern=%0b", f, scale_sel, pattern_en);
            for (int k = 0; k < FT * D; k++) begin
                @(negedge clk);
                if (k == chg_at) begin
                    scale_sel  = 2'($urandom_range(0, 3));
                    pattern_en = 1'($urandom_range(0, 1));
                end
                c   = cyc;
                n   = c / D;
                pa  = n - 1;
                pp  = n - PL;
                er  = exp_rgb(pp);
                got = {vif.VGA_R, vif.VGA_G, vif.VGA_B};
                total++; if (vif.raddr_vga !== 12'(exp_addr(pa))) begin bad++; $display("FAIL rand_addr cyc=%0d got=%0d want=%0d", c, vif.raddr_vga, exp_addr(pa)); end
                total++; if (got !== er) begin bad++; $display("FAIL rand_rgb cyc=%0d got=%03h want=%03h", c, got, er); end
                total++; if (vif.VGA_HS !== exp_hs(pp)) begin bad++; $display("FAIL rand_hs cyc=%0d got=%0b want=%0b", c, vif.VGA_HS, exp_hs(pp)); end
                total++; if (vif.VGA_VS !== exp_vs(pp)) begin bad++; $display("FAIL rand_vs cyc=%0d got=%0b want=%0b", c, vif.VGA_VS, exp_vs(pp)); end
            end
        end
    endtask

    initial begin
        key = 12'($urandom);
        test_reset();
        test_timing();
        test_addr(2'd0, 1, 1'b0, 2'd0);
        test_addr(2'd1, 2, 1'b1, 2'd0);
        test_addr(2'd3, 1, 1'b0, 2'd0);
        test_pixels(2'd0, 1'b0, 1);
        test_pixels(2'd1, 1'b0, 1);
        test_pixels(2'd0, 1'b1, 1);
        test_async_reset();
        test_random(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
